lsu_mem_master: RTL and testbench

//  Load/store initiator between the core datapath and the word-organised data memory.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_align.sv | 32 +++
 rtl/lsu_mem_master.sv | 125 ++++++++++++
 tb/tb_lsu_mem_master.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and access-size helpers for the LSU
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE} state_e;
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    return sz == 2'b00 ? 4'b0001 : sz == 2'b01 ? 4'b0011 : 4'b1111;
  endfunction
  function automatic logic legal_f3(input logic wr, input logic [2:0] f3);
    return wr ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
              : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction
  // an access crosses a word boundary when off + size > 4
  function automatic logic needs_split(input logic [2:0] f3, input logic [1:0] off);
    return f3[1:0] == 2'b10 ? off != 2'd0 : (f3[1:0] == 2'b01 && off == 2'd3);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane shifting / byte enables and load merge / extension
module lsu_align import lsu_pkg::*; (
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] load_val
);
  logic [3:0]  mask;
  logic [7:0]  be_wide;
  logic [5:0]  sh;
  logic [31:0] merged;
  always_comb begin
    mask     = size_mask(funct3[1:0]);
    sh       = {1'b0, off, 3'b000};
    be_wide  = {4'b0000, mask} << off;
    be0      = be_wide[3:0];
    be1      = mask >> (3'd4 - {1'b0, off});
    wdata0   = store_data << sh;
    wdata1   = store_data >> (6'd32 - sh);
    merged   = (d0 >> sh) | (d1 << (6'd32 - sh));
    load_val = funct3 == F3_B  ? {{24{merged[7]}}, merged[7:0]} :
               funct3 == F3_H  ? {{16{merged[15]}}, merged[15:0]} :
               funct3 == F3_BU ? {24'b0, merged[7:0]} :
               funct3 == F3_HU ? {16'b0, merged[15:0]} : merged;
  end
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator issuing one or two word beats per access
module lsu_mem_master import lsu_pkg::*; #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       rs1,
  input  logic [31:0]       imm,
  input  logic [31:0]       store_data,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       load_result,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);
  state_e            state_q, state_d;
  logic              write_q, write_d, err_q, err_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       sdata_q, sdata_d, d0_q, d0_d, result_q, result_d;
  logic [31:0]       ea, wdata0, wdata1, load_val;
  logic [3:0]        be0, be1;
  logic              split, unused_ea;
  assign ea        = rs1 + imm;
  assign unused_ea = ^ea[31:ADDR_W+2];
  assign split     = needs_split(f3_q, off_q);
  lsu_align u_align (
    .funct3    (f3_q),
    .off       (off_q),
    .store_data(sdata_q),
    .d0        (state_q == S_WAIT0 ? mem_rdata : d0_q),
    .d1        (state_q == S_WAIT1 ? mem_rdata : 32'h0),
    .be0       (be0),
    .be1       (be1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .load_val  (load_val)
  );
  always_comb begin
    req_ready   = state_q == S_IDLE;
    mem_valid   = state_q == S_REQ0 || state_q == S_REQ1;
    mem_we      = mem_valid && write_q;
    mem_addr    = state_q == S_REQ1 ? word_q + ADDR_W'(1) : state_q == S_REQ0 ? word_q : '0;
    mem_be      = state_q == S_REQ1 ? be1 : state_q == S_REQ0 ? be0 : 4'b0000;
    mem_wdata   = !mem_we ? 32'h0 : state_q == S_REQ1 ? wdata1 : wdata0;
    resp_valid  = state_q == S_DONE;
    resp_err    = resp_valid && err_q;
    load_result = result_q;
  end
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    err_d    = err_q;
    f3_d     = f3_q;
    word_d   = word_q;
    off_d    = off_q;
    sdata_d  = sdata_q;
    d0_d     = d0_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: if (req_valid) begin
        write_d = req_write;
        f3_d    = req_funct3;
        word_d  = ea[ADDR_W+1:2];
        off_d   = ea[1:0];
        sdata_d = store_data;
        err_d   = !legal_f3(req_write, req_funct3);
        state_d = legal_f3(req_write, req_funct3) ? S_REQ0 : S_DONE;
        if (!legal_f3(req_write, req_funct3)) result_d = '0;
      end
      S_REQ0: if (mem_ready) begin
        state_d = !write_q ? S_WAIT0 : split ? S_REQ1 : S_DONE;
        if (write_q && !split) result_d = '0;
      end
      S_WAIT0: if (mem_rvalid) begin
        d0_d     = mem_rdata;
        state_d  = split ? S_REQ1 : S_DONE;
        result_d = split ? result_q : load_val;
      end
      S_REQ1: if (mem_ready) begin
        state_d = write_q ? S_DONE : S_WAIT1;
        if (write_q) result_d = '0;
      end
      S_WAIT1: if (mem_rvalid) begin
        state_d  = S_DONE;
        result_d = load_val;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      f3_q     <= '0;
      word_q   <= '0;
      off_q    <= '0;
      sdata_q  <= '0;
      d0_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      err_q    <= err_d;
      f3_q     <= f3_d;
      word_q   <= word_d;
      off_q    <= off_d;
      sdata_q  <= sdata_d;
      d0_q     <= d0_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: scoreboard bench with a byte-level reference memory and a randomized memory slave
module tb_lsu_mem_master;
  logic        clk = 1'b0, rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] rs1, imm, store_data;
  logic        resp_valid, resp_err;
  logic [31:0] load_result;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [4:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .rs1(rs1), .imm(imm), .store_data(store_data),
    .resp_valid(resp_valid), .resp_err(resp_err), .load_result(load_result),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct packed {logic ld; logic err; logic [31:0] res;} exp_t;
  typedef struct packed {logic we; logic [4:0] addr; logic [3:0] be; logic [31:0] wdata;} beat_t;

  int checks = 0, failures = 0, cyc = 0;
  int resp_cnt = 0, resp_cyc = 0, acc_cyc = 0;
  int force_stall = 0, rd_delay_fix = -1;
  bit fast = 1'b1;
  logic [31:0] last_res;
  exp_t  sb[$];
  exp_t  mon_e;
  beat_t beats[$];
  logic [7:0]  ref_b [128];
  logic [31:0] smem [32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // response monitor: pops the scoreboard on every completion pulse
  always @(negedge clk) if (!rst && resp_valid) begin
    resp_cnt++;
    resp_cyc = cyc;
    last_res = load_result;
    if (sb.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
    else begin
      mon_e = sb.pop_front();
      check("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
      if (mon_e.ld || mon_e.err) check("load_result", load_result, mon_e.res);
    end
  end

  // memory slave: random ready stalls, random read latency, spurious rvalid while idle
  initial begin
    bit          rd_pend, stall_prev;
    int          rd_wait;
    logic [31:0] rd_data;
    logic [41:0] prev_beat;
    rd_pend = 0; stall_prev = 0; rd_wait = 0; rd_data = 0; prev_beat = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (stall_prev && !rst) begin
        check("stall_hold_valid", {31'b0, mem_valid}, 32'd1);
        check("stall_stable_beat", {31'b0, {mem_we, mem_addr, mem_be, mem_wdata} == prev_beat}, 32'd1);
      end
      mem_rvalid = 0;
      mem_rdata  = $urandom;
      if (rd_pend) begin
        if (rd_wait == 0) begin
          mem_rvalid = 1; mem_rdata = rd_data; rd_pend = 0;
        end else rd_wait--;
      end else if (!fast && req_ready && $urandom_range(0, 3) == 0) mem_rvalid = 1;
      if (force_stall > 0 && mem_valid) begin
        mem_ready = 0;
        force_stall--;
      end else mem_ready = mem_valid && (fast || $urandom_range(0, 2) != 0);
      stall_prev = mem_valid && !mem_ready && !rst;
      prev_beat  = {mem_we, mem_addr, mem_be, mem_wdata};
      if (mem_valid && mem_ready && !rst) begin
        beats.push_back({mem_we, mem_addr, mem_be, mem_wdata});
        if (mem_we) begin
          for (int l = 0; l < 4; l++) if (mem_be[l]) smem[mem_addr][8*l +: 8] = mem_wdata[8*l +: 8];
        end else begin
          rd_pend = 1;
          rd_wait = rd_delay_fix >= 0 ? rd_delay_fix : (fast ? 0 : int'($urandom_range(0, 3)));
          rd_data = smem[mem_addr];
        end
      end
    end
  end

  // issues one request; the reference model works on a 128-byte array
  task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d);
    exp_t e;
    logic [31:0] ea, v;
    int sz, t;
    t = 0;
    while (!req_ready && t < 300) begin @(posedge clk); #1; t++; end
    if (t >= 300) check("req_ready_timeout", 32'd1, 32'd0);
    req_valid = 1; req_write = w; req_funct3 = f3; rs1 = a; imm = b; store_data = d;
    acc_cyc = cyc;
    ea = a + b;
    sz = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    e.ld  = !w;
    e.err = w ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    v = 0;
    if (!e.err) begin
      for (int i = 0; i < sz; i++)
        if (w) ref_b[(int'(ea[6:0]) + i) % 128] = d[8*i +: 8];
        else v[8*i +: 8] = ref_b[(int'(ea[6:0]) + i) % 128];
      if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
    end
    e.res = v;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || !req_ready) && t < 500) begin @(posedge clk); #1; t++; end
    if (t >= 500) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 0;
    sb.delete();
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
  endtask

  logic [2:0]  t3_f3  [6] = '{3'd0, 3'd0, 3'd4, 3'd5, 3'd0, 3'd1};
  logic [31:0] t3_ea  [6] = '{32'h16, 32'h17, 32'h17, 32'h14, 32'h15, 32'h16};
  logic [31:0] t3_exp [6] = '{32'hFFFFFFFF, 32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'h0000007F, 32'hFFFF80FF};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 128; i++) begin
      ref_b[i] = 8'($urandom);
      smem[i/4][8*(i%4) +: 8] = ref_b[i];
    end
    rst = 1; req_valid = 0; req_write = 0; req_funct3 = 0; rs1 = 0; imm = 0; store_data = 0;
    @(posedge clk); #1;
    do_reset();
    check("rst_load_result", load_result, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", {27'b0, mem_addr}, 32'd0);
    check("rst_mem_be", {28'b0, mem_be}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    // aligned word store then load
    beats.delete();
    issue(1, 3'd2, 32'h10, 32'h4, 32'hDEADBEEF); wait_idle();
    check("sw_beats", beats.size(), 32'd1);
    check("sw_beat", {beats[0].we, beats[0].addr, beats[0].be, beats[0].wdata[21:0]},
          {1'b1, 5'd5, 4'hF, 22'h2DBEEF});
    check("sw_wdata", beats[0].wdata, 32'hDEADBEEF);
    check("sw_latency", resp_cyc - acc_cyc, 32'd2);
    issue(0, 3'd2, 32'h10, 32'h4, 32'h0); wait_idle();
    check("lw_value", last_res, 32'hDEADBEEF);
    check("lw_latency", resp_cyc - acc_cyc, 32'd3);
    // byte/half loads with sign and zero extension
    issue(1, 3'd2, 32'h14, 32'h0, 32'h80FF7F01); wait_idle();
    for (int i = 0; i < 6; i++) begin
      issue(0, t3_f3[i], t3_ea[i], 32'h0, 32'h0); wait_idle();
      check("narrow_load", last_res, t3_exp[i]);
    end
    // word store and load wrapping across the top of memory
    beats.delete();
    issue(1, 3'd2, 32'h7F, 32'h0, 32'h11223344); wait_idle();
    check("split_sw_beats", beats.size(), 32'd2);
    check("split_b0", {beats[0].addr, beats[0].be}, {5'd31, 4'b1000});
    check("split_b0_wdata", beats[0].wdata, 32'h44000000);
    check("split_b1", {beats[1].addr, beats[1].be}, {5'd0, 4'b0111});
    check("split_b1_wdata", beats[1].wdata, 32'h00112233);
    check("split_sw_latency", resp_cyc - acc_cyc, 32'd3);
    issue(0, 3'd2, 32'h70, 32'hF, 32'h0); wait_idle();
    check("split_lw_value", last_res, 32'h11223344);
    check("split_lw_latency", resp_cyc - acc_cyc, 32'd5);
    // ready held low for three cycles
    beats.delete();
    force_stall = 3;
    issue(1, 3'd1, 32'h20, 32'h2, 32'h0000ABCD); wait_idle();
    check("stall_beats", beats.size(), 32'd1);
    check("stall_beat", {beats[0].addr, beats[0].be}, {5'd8, 4'b1100});
    check("stall_wdata", beats[0].wdata, 32'hABCD0000);
    check("stall_latency", resp_cyc - acc_cyc, 32'd5);
    // illegal codes complete without touching memory
    beats.delete();
    issue(0, 3'd3, 32'h0, 32'h0, 32'h0); wait_idle();
    check("illegal_latency", resp_cyc - acc_cyc, 32'd1);
    issue(1, 3'd4, 32'h8, 32'h0, 32'h12345678); wait_idle();
    check("illegal_beats", beats.size(), 32'd0);
    // reset while waiting for read data
    rd_delay_fix = 3;
    n = resp_cnt;
    issue(0, 3'd2, 32'h40, 32'h0, 32'h0);
    @(posedge clk); #1;
    do_reset();
    repeat (6) begin @(posedge clk); #1; end
    check("no_resp_after_rst", resp_cnt, n);
    rd_delay_fix = -1;
    // randomized traffic, with one reset landing on an in-flight load
    fast = 0;
    for (int k = 0; k < 300; k++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      wait_idle();
      if (k == 150) begin
        n = resp_cnt;
        issue(0, 3'd2, $urandom, $urandom, 32'h0);
        do_reset();
        repeat (6) begin @(posedge clk); #1; end
        check("no_resp_mid_traffic_rst", resp_cnt, n);
      end
    end
    wait_idle();
    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
